// File: rtl/ex_div_ctrl_pkg.sv
// Shared execute-stage defines for the divide path: opcodes, sequencer and
// divider state encodings, and the divider handshake constants.
package ex_div_ctrl_pkg;

    localparam logic [7:0] EXE_DIV_OP  = 8'b00011010;
    localparam logic [7:0] EXE_DIVU_OP = 8'b00011011;

    localparam logic DIV_START     = 1'b1;
    localparam logic DIV_STOP      = 1'b0;
    localparam logic DIV_READY     = 1'b1;
    localparam logic DIV_NOT_READY = 1'b0;
    localparam logic DIV_CANCEL    = 1'b1;
    localparam logic DIV_NO_CANCEL = 1'b0;

    // Sequencer states in EX.
    typedef enum logic [1:0] {
        DIV_IDLE = 2'd0,
        DIV_BUSY = 2'd1,
        DIV_DONE = 2'd2
    } div_state_e;

    // Divider core states, shared with the divider instantiated beside this block.
    typedef enum logic [1:0] {
        DIVR_FREE    = 2'd0,
        DIVR_BY_ZERO = 2'd1,
        DIVR_ON      = 2'd2,
        DIVR_END     = 2'd3
    } divider_state_e;

    function automatic logic is_div_op(input logic [7:0] op);
        return (op == EXE_DIV_OP) || (op == EXE_DIVU_OP);
    endfunction

endpackage

// File: rtl/ex_div_ctrl.sv
// EX-stage divide sequencer: latches operands, drives the divider start/cancel
// handshake, stalls the pipeline while a divide runs and returns HI/LO.
module ex_div_ctrl
    import ex_div_ctrl_pkg::*;
(
    input  logic        clk,
    input  logic        rst,
    input  logic [7:0]  aluop_i,
    input  logic [31:0] reg1_i,
    input  logic [31:0] reg2_i,
    input  logic        flush_i,
    input  logic        stall_i,
    input  logic [63:0] div_result_i,
    input  logic        div_ready_i,
    output logic [31:0] div_opdata1_o,
    output logic [31:0] div_opdata2_o,
    output logic        div_signed_o,
    output logic        div_start_o,
    output logic        div_cancel_o,
    output logic        stallreq_o,
    output logic        whilo_o,
    output logic [31:0] hi_o,
    output logic [31:0] lo_o
);

    div_state_e  state_q, state_d;
    logic        armed_q, armed_d;
    logic        start_q, start_d;
    logic        signed_q, signed_d;
    logic [31:0] op1_q, op1_d;
    logic [31:0] op2_q, op2_d;
    logic [31:0] hi_hold_q, hi_hold_d;
    logic [31:0] lo_hold_q, lo_hold_d;

    // State, handshake and operand/result hold registers.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q   <= DIV_IDLE;
            armed_q   <= 1'b0;
            start_q   <= DIV_STOP;
            signed_q  <= 1'b0;
            op1_q     <= '0;
            op2_q     <= '0;
            hi_hold_q <= '0;
            lo_hold_q <= '0;
        end else begin
            state_q   <= state_d;
            armed_q   <= armed_d;
            start_q   <= start_d;
            signed_q  <= signed_d;
            op1_q     <= op1_d;
            op2_q     <= op2_d;
            hi_hold_q <= hi_hold_d;
            lo_hold_q <= lo_hold_d;
        end
    end

    // Next-state and combinational outputs. A ready is only honoured once the
    // divider has been seen not-ready during this divide (armed), so a ready
    // left over from the previous divide is never taken as this result.
    always_comb begin
        state_d      = state_q;
        armed_d      = armed_q;
        start_d      = start_q;
        signed_d     = signed_q;
        op1_d        = op1_q;
        op2_d        = op2_q;
        hi_hold_d    = hi_hold_q;
        lo_hold_d    = lo_hold_q;
        stallreq_o   = 1'b0;
        whilo_o      = 1'b0;
        hi_o         = '0;
        lo_o         = '0;
        div_cancel_o = DIV_NO_CANCEL;

        unique case (state_q)
            DIV_IDLE: begin
                start_d = DIV_STOP;
                if (is_div_op(aluop_i) && !flush_i) begin
                    stallreq_o = 1'b1;
                    op1_d      = reg1_i;
                    op2_d      = reg2_i;
                    signed_d   = (aluop_i == EXE_DIV_OP);
                    start_d    = DIV_START;
                    armed_d    = 1'b0;
                    state_d    = DIV_BUSY;
                end
            end
            DIV_BUSY: begin
                stallreq_o = 1'b1;
                if (div_ready_i == DIV_NOT_READY) begin
                    armed_d = 1'b1;
                end
                if (flush_i) begin
                    div_cancel_o = DIV_CANCEL;
                    start_d      = DIV_STOP;
                    state_d      = DIV_IDLE;
                end else if (armed_q && (div_ready_i == DIV_READY)) begin
                    stallreq_o = 1'b0;
                    whilo_o    = 1'b1;
                    hi_o       = div_result_i[63:32];
                    lo_o       = div_result_i[31:0];
                    hi_hold_d  = div_result_i[63:32];
                    lo_hold_d  = div_result_i[31:0];
                    start_d    = DIV_STOP;
                    state_d    = stall_i ? DIV_DONE : DIV_IDLE;
                end
            end
            DIV_DONE: begin
                start_d = DIV_STOP;
                if (flush_i) begin
                    state_d = DIV_IDLE;
                end else begin
                    whilo_o = 1'b1;
                    hi_o    = hi_hold_q;
                    lo_o    = lo_hold_q;
                    if (!stall_i) begin
                        state_d = DIV_IDLE;
                    end
                end
            end
            default: begin
                state_d = DIV_IDLE;
            end
        endcase
    end

    assign div_start_o   = start_q;
    assign div_signed_o  = signed_q;
    assign div_opdata1_o = op1_q;
    assign div_opdata2_o = op2_q;

endmodule

// File: tb/tb_ex_div_ctrl.sv
// Self-checking bench for ex_div_ctrl with a behavioural divider and a
// transaction-level reference model checked on every falling edge.
module tb_ex_div_ctrl;

    localparam logic [7:0] OP_DIV  = 8'h1A;
    localparam logic [7:0] OP_DIVU = 8'h1B;
    localparam logic [7:0] OP_NOP  = 8'h00;
    localparam int unsigned LAT = 12;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic [7:0]  aluop_i = OP_NOP;
    logic [31:0] reg1_i = '0;
    logic [31:0] reg2_i = '0;
    logic        flush_i = 1'b0;
    logic        stall_i = 1'b0;
    logic [63:0] div_result_i;
    logic        div_ready_i;
    logic [31:0] div_opdata1_o, div_opdata2_o;
    logic        div_signed_o, div_start_o, div_cancel_o, stallreq_o, whilo_o;
    logic [31:0] hi_o, lo_o;

    int errors = 0;
    int checks = 0;

    ex_div_ctrl dut (
        .clk(clk), .rst(rst), .aluop_i(aluop_i), .reg1_i(reg1_i), .reg2_i(reg2_i),
        .flush_i(flush_i), .stall_i(stall_i), .div_result_i(div_result_i),
        .div_ready_i(div_ready_i), .div_opdata1_o(div_opdata1_o),
        .div_opdata2_o(div_opdata2_o), .div_signed_o(div_signed_o),
        .div_start_o(div_start_o), .div_cancel_o(div_cancel_o),
        .stallreq_o(stallreq_o), .whilo_o(whilo_o), .hi_o(hi_o), .lo_o(lo_o)
    );

    always #5 clk = ~clk;

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h, expected %0h (t=%0t)", name, act, exp, $time);
        end
    endtask

    function automatic logic [63:0] ref_div(input logic [31:0] a, input logic [31:0] b,
                                            input logic s);
        logic [31:0] q, r;
        if (b == 32'd0) return '0;
        if (s) begin
            q = $signed(a) / $signed(b);
            r = $signed(a) % $signed(b);
        end else begin
            q = a / b;
            r = a % b;
        end
        return {r, q};
    endfunction

    // Behavioural divider: ready stays up until the next start is accepted,
    // so a stale ready is visible at the start of a following divide.
    logic [1:0]  dv_st;
    int unsigned dv_cnt;
    logic        dv_rdy;
    logic [63:0] dv_res;
    always @(posedge clk or posedge rst) begin
        if (rst) begin
            dv_st <= 2'd0; dv_cnt <= 0; dv_rdy <= 1'b0; dv_res <= '0;
        end else begin
            case (dv_st)
                2'd0: if (div_start_o && !div_cancel_o) begin
                    dv_st <= 2'd1; dv_cnt <= 0; dv_rdy <= 1'b0;
                    dv_res <= ref_div(div_opdata1_o, div_opdata2_o, div_signed_o);
                end
                2'd1: if (div_cancel_o || !div_start_o) begin
                    dv_st <= 2'd0; dv_rdy <= 1'b0;
                end else if (dv_cnt == LAT) begin
                    dv_st <= 2'd2; dv_rdy <= 1'b1;
                end else begin
                    dv_cnt <= dv_cnt + 1;
                end
                default: if (!div_start_o) dv_st <= 2'd0;
            endcase
        end
    end
    assign div_ready_i  = dv_rdy;
    assign div_result_i = dv_res;

    // Reference model: a divide is "in flight" from the edge after detection
    // until a trusted ready or a flush; a "held" result repeats while EX stalls.
    bit          m_busy, m_seen_low, m_held, m_sgn;
    logic [31:0] m_op1, m_op2;
    logic [63:0] m_res;
    initial begin
        logic e_stall, e_whilo, e_cancel;
        logic [31:0] e_hi, e_lo;
        bit n_busy, n_held;
        m_busy = 0; m_seen_low = 0; m_held = 0; m_sgn = 0;
        m_op1 = '0; m_op2 = '0; m_res = '0;
        forever begin
            @(negedge clk);
            e_stall = 0; e_whilo = 0; e_cancel = 0; e_hi = '0; e_lo = '0;
            n_busy = m_busy; n_held = m_held;
            if (rst) begin
                m_busy = 0; m_seen_low = 0; m_held = 0; m_sgn = 0;
                m_op1 = '0; m_op2 = '0; n_busy = 0; n_held = 0;
            end else if (m_held) begin
                if (!flush_i) begin
                    e_whilo = 1; {e_hi, e_lo} = m_res;
                end
                if (flush_i || !stall_i) n_held = 0;
            end else if (m_busy) begin
                if (flush_i) begin
                    e_cancel = 1; e_stall = 1; n_busy = 0;
                end else if (m_seen_low && div_ready_i) begin
                    e_whilo = 1; {e_hi, e_lo} = div_result_i;
                    m_res = div_result_i; n_busy = 0; n_held = stall_i;
                end else begin
                    e_stall = 1;
                end
                if (!div_ready_i) m_seen_low = 1;
            end else if ((aluop_i == OP_DIV || aluop_i == OP_DIVU) && !flush_i) begin
                e_stall = 1; n_busy = 1;
            end
            chk("stallreq_o", stallreq_o, e_stall);
            chk("whilo_o", whilo_o, e_whilo);
            chk("hi_o", hi_o, e_hi);
            chk("lo_o", lo_o, e_lo);
            chk("div_cancel_o", div_cancel_o, e_cancel);
            chk("div_start_o", div_start_o, m_busy);
            chk("div_opdata1_o", div_opdata1_o, m_op1);
            chk("div_opdata2_o", div_opdata2_o, m_op2);
            chk("div_signed_o", div_signed_o, m_sgn);
            if (!rst && !m_busy && !m_held && n_busy) begin
                m_op1 = reg1_i; m_op2 = reg2_i; m_sgn = (aluop_i == OP_DIV); m_seen_low = 0;
            end
            m_busy = n_busy; m_held = n_held;
        end
    end

    // Presents one divide in EX and keeps it there until its result leaves.
    task automatic run_div(input logic [7:0] op, input logic [31:0] a, input logic [31:0] b,
                           input int unsigned nstall, output logic [31:0] rhi,
                           output logic [31:0] rlo, output int unsigned wcnt,
                           output int unsigned pre_low);
        bit got, started, done;
        int unsigned scnt;
        got = 0; started = 0; done = 0; scnt = 0;
        rhi = '0; rlo = '0; wcnt = 0; pre_low = 0;
        aluop_i = op; reg1_i = a; reg2_i = b; stall_i = (nstall != 0);
        for (int cyc = 0; cyc < 300 && !done; cyc++) begin
            @(negedge clk);
            if (!started) begin
                if (div_start_o) started = 1;
                else pre_low++;
            end
            if (whilo_o) begin
                if (!got) begin rhi = hi_o; rlo = lo_o; got = 1; end
                wcnt++;
                if (!stall_i) done = 1;
                else scnt++;
            end
            @(posedge clk); #1;
            if (stall_i && scnt >= nstall) stall_i = 0;
        end
        chk("run_div_completed", done, 1'b1);
        aluop_i = OP_NOP; stall_i = 0;
    endtask

    initial begin
        logic [31:0] h, l;
        int unsigned w, pl, ccnt, wc;
        repeat (3) @(posedge clk);
        #1;
        chk("reset_start", div_start_o, 1'b0);
        chk("reset_stallreq", stallreq_o, 1'b0);
        chk("reset_opdata1", div_opdata1_o, 32'd0);
        rst = 0;
        @(posedge clk); #1;

        run_div(OP_DIV, 32'd100, 32'd7, 0, h, l, w, pl);
        chk("div100_7_hi", h, 32'd2);
        chk("div100_7_lo", l, 32'd14);
        chk("div100_7_whilo_cycles", w, 1);
        chk("div100_7_start_fell", div_start_o, 1'b0);

        run_div(OP_DIV, 32'hFFFF_FFF9, 32'd2, 0, h, l, w, pl);
        chk("divm7_2_hi", h, 32'hFFFF_FFFF);
        chk("divm7_2_lo", l, 32'hFFFF_FFFD);

        run_div(OP_DIVU, 32'hFFFF_FFFF, 32'd2, 0, h, l, w, pl);
        chk("divu_max_2_hi", h, 32'd1);
        chk("divu_max_2_lo", l, 32'h7FFF_FFFF);

        run_div(OP_DIVU, 32'd5, 32'd0, 0, h, l, w, pl);
        chk("divu5_0_hi", h, 32'd0);
        chk("divu5_0_lo", l, 32'd0);
        chk("divu5_0_whilo_cycles", w, 1);

        // reset in the middle of a divide
        aluop_i = OP_DIV; reg1_i = 32'd50; reg2_i = 32'd5;
        repeat (5) @(posedge clk);
        #1;
        aluop_i = OP_NOP; rst = 1;
        #1;
        chk("midreset_start", div_start_o, 1'b0);
        chk("midreset_stallreq", stallreq_o, 1'b0);
        @(posedge clk); #1;
        rst = 0;
        @(posedge clk); #1;

        // flush ten cycles into a divide
        aluop_i = OP_DIV; reg1_i = 32'd1000; reg2_i = 32'd3;
        repeat (10) @(posedge clk);
        #1;
        flush_i = 1; aluop_i = OP_NOP;
        ccnt = 0; wc = 0;
        for (int i = 0; i < 30; i++) begin
            @(negedge clk);
            ccnt += div_cancel_o;
            wc += whilo_o;
            @(posedge clk); #1;
            flush_i = 0;
        end
        chk("flush_cancel_cycles", ccnt, 1);
        chk("flush_whilo_cycles", wc, 0);
        chk("flush_start_low", div_start_o, 1'b0);
        run_div(OP_DIV, 32'd9, 32'd3, 0, h, l, w, pl);
        chk("div9_3_hi", h, 32'd0);
        chk("div9_3_lo", l, 32'd3);

        // back-to-back, no stall
        run_div(OP_DIV, 32'd20, 32'd6, 0, h, l, w, pl);
        chk("b2b_a_hi", h, 32'd2);
        chk("b2b_a_lo", l, 32'd3);
        run_div(OP_DIV, 32'd7, 32'd7, 0, h, l, w, pl);
        chk("b2b_start_gap", pl, 1);
        chk("b2b_b_hi", h, 32'd0);
        chk("b2b_b_lo", l, 32'd1);

        // back-to-back with a 3-cycle stall at the first ready
        run_div(OP_DIV, 32'd20, 32'd6, 3, h, l, w, pl);
        chk("stall_a_hi", h, 32'd2);
        chk("stall_a_lo", l, 32'd3);
        chk("stall_a_whilo_cycles", w, 4);
        run_div(OP_DIV, 32'd7, 32'd7, 0, h, l, w, pl);
        chk("stall_b_hi", h, 32'd0);
        chk("stall_b_lo", l, 32'd1);

        repeat (3) @(posedge clk);
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
